// File: rtl/antenna_sel_latch.sv
// Antenna request debounce, interlock and commit stage for the 6x2 antenna switch.
// Publishes a committed code (X1) and a hold-delayed reference code (X2) per radio.
module antenna_sel_latch #(
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned HOLD_CYC     = 50000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       I_CLK,
    input  logic       I_nRST,
    input  logic [2:0] I_REQ_A,
    input  logic [2:0] I_REQ_B,
    output logic [2:0] O_A1,
    output logic [2:0] O_A2,
    output logic [2:0] O_B1,
    output logic [2:0] O_B2,
    output logic       O_CONFLICT
);

    localparam int unsigned DbW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYC - 1);
    localparam logic [2:0] CodeOff = 3'd0;
    localparam logic [2:0] CodeInvalid = 3'd7;

    typedef enum logic {StIdle, StHold} hold_st_e;

    logic [2:0]       samp_a_q, samp_b_q;
    logic [DbW-1:0]   dcnt_a_q, dcnt_a_d, dcnt_b_q, dcnt_b_d;
    logic [2:0]       a1_q, a1_d, b1_q, b1_d;
    logic [2:0]       a2_q, a2_d, b2_q, b2_d;
    logic             conflict_q, conflict_d;
    hold_st_e         st_q, st_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;

    logic stable_a, stable_b;
    logic cand_a, cand_b;
    logic blk_a, blk_b;
    logic commit_a, commit_b, commit_any;

    always_comb begin
        dcnt_a_d = dcnt_a_q;
        dcnt_b_d = dcnt_b_q;
        if (I_REQ_A != samp_a_q) begin
            dcnt_a_d = '0;
        end else if (dcnt_a_q != DbMax) begin
            dcnt_a_d = dcnt_a_q + 1'b1;
        end
        if (I_REQ_B != samp_b_q) begin
            dcnt_b_d = '0;
        end else if (dcnt_b_q != DbMax) begin
            dcnt_b_d = dcnt_b_q + 1'b1;
        end
    end

    assign stable_a = (dcnt_a_q == DbMax);
    assign stable_b = (dcnt_b_q == DbMax);
    assign cand_a   = stable_a && (samp_a_q != a1_q) && (samp_a_q != CodeInvalid);
    assign cand_b   = stable_b && (samp_b_q != b1_q) && (samp_b_q != CodeInvalid);

    // A wins a same-cycle tie for the same antenna, so only B checks the other candidate.
    assign blk_a = cand_a && (samp_a_q != CodeOff) && (samp_a_q == b1_q);
    assign blk_b = cand_b && (samp_b_q != CodeOff) &&
                   ((samp_b_q == a1_q) || (cand_a && (samp_a_q == samp_b_q)));

    assign commit_a   = cand_a && !blk_a;
    assign commit_b   = cand_b && !blk_b;
    assign commit_any = commit_a || commit_b;
    assign conflict_d = blk_a || blk_b;

    assign a1_d = commit_a ? samp_a_q : a1_q;
    assign b1_d = commit_b ? samp_b_q : b1_q;

    always_comb begin
        st_d   = st_q;
        hcnt_d = hcnt_q;
        a2_d   = a2_q;
        b2_d   = b2_q;
        unique case (st_q)
            StIdle: begin
                if (commit_any) begin
                    st_d   = StHold;
                    hcnt_d = HoldLoad;
                end
            end
            StHold: begin
                if (commit_any) begin
                    hcnt_d = HoldLoad;
                end else if (hcnt_q == '0) begin
                    a2_d = a1_q;
                    b2_d = b1_q;
                    st_d = StIdle;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_nRST) begin
        if (!I_nRST) begin
            samp_a_q   <= '0;
            samp_b_q   <= '0;
            dcnt_a_q   <= '0;
            dcnt_b_q   <= '0;
            a1_q       <= '0;
            b1_q       <= '0;
            a2_q       <= '0;
            b2_q       <= '0;
            conflict_q <= 1'b0;
            st_q       <= StIdle;
            hcnt_q     <= '0;
        end else begin
            samp_a_q   <= I_REQ_A;
            samp_b_q   <= I_REQ_B;
            dcnt_a_q   <= dcnt_a_d;
            dcnt_b_q   <= dcnt_b_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            a2_q       <= a2_d;
            b2_q       <= b2_d;
            conflict_q <= conflict_d;
            st_q       <= st_d;
            hcnt_q     <= hcnt_d;
        end
    end

    assign O_A1       = a1_q;
    assign O_A2       = a2_q;
    assign O_B1       = b1_q;
    assign O_B2       = b2_q;
    assign O_CONFLICT = conflict_q;

endmodule

// File: tb/tb_antenna_sel_latch.sv
// Scoreboard bench for antenna_sel_latch with DEBOUNCE_CYC=4, HOLD_CYC=8.
// Stimulus schedules expected output snapshots per cycle; a negedge monitor checks them.
module tb_antenna_sel_latch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] req_a = 3'd0;
    logic [2:0] req_b = 3'd0;
    logic [2:0] o_a1, o_a2, o_b1, o_b2;
    logic       o_conflict;

    antenna_sel_latch #(
        .DEBOUNCE_CYC(4),
        .HOLD_CYC    (8),
        .CNT_W       (4)
    ) dut (
        .I_CLK     (clk),
        .I_nRST    (rst_n),
        .I_REQ_A   (req_a),
        .I_REQ_B   (req_b),
        .O_A1      (o_a1),
        .O_A2      (o_a2),
        .O_B1      (o_b1),
        .O_B2      (o_b2),
        .O_CONFLICT(o_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot layout: {A1, A2, B1, B2, CONFLICT}
    localparam logic [12:0] MA1  = 13'h1C00;
    localparam logic [12:0] MA2  = 13'h0380;
    localparam logic [12:0] MB1  = 13'h0070;
    localparam logic [12:0] MB2  = 13'h000E;
    localparam logic [12:0] MCF  = 13'h0001;
    localparam logic [12:0] MALL = 13'h1FFF;

    typedef struct {
        int          cyc;
        string       name;
        logic [12:0] exp;
        logic [12:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [12:0] pk(logic [2:0] a1, logic [2:0] a2, logic [2:0] b1,
                                       logic [2:0] b2, logic cf);
        return {a1, a2, b1, b2, cf};
    endfunction

    task automatic expect_at(int c, string nm, logic [12:0] e, logic [12:0] m);
        exp_t x;
        int   i;
        x.cyc  = c;
        x.name = nm;
        x.exp  = e;
        x.mask = m;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, x);
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: checks the interlock invariant every cycle and pops due expectations.
    initial begin
        exp_t        x;
        logic [12:0] act;
        forever begin
            @(negedge clk);
            act = pk(o_a1, o_a2, o_b1, o_b2, o_conflict);
            n_chk++;
            if (o_a1 == o_b1 && o_a1 != 3'd0) begin
                n_fail++;
                $display("FAIL interlock at cycle %0d: A1=%0d B1=%0d, required distinct",
                         cyc, o_a1, o_b1);
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                x = sb.pop_front();
                n_chk++;
                if (x.cyc < cyc || ((act ^ x.exp) & x.mask) != 13'd0) begin
                    n_fail++;
                    $display("FAIL %s at cycle %0d (due %0d): got %h required %h mask %h",
                             x.name, cyc, x.cyc, act & x.mask, x.exp & x.mask, x.mask);
                end
            end
        end
    end

    initial begin
        int b, b2, b3;
        #1 rst_n = 1'b0;
        wait_cyc(2);
        expect_at(2, "reset_state", pk(0, 0, 0, 0, 0), MALL);
        expect_at(3, "reset_state", pk(0, 0, 0, 0, 0), MALL);
        wait_cyc(4);

        // S1: single commit then hold expiry
        b = cyc;
        rst_n = 1'b1;
        req_a = 3'd3;
        for (int i = 0; i <= 13; i++) expect_at(b + i, "s1_b_idle", 13'd0, MB1 | MB2 | MCF);
        expect_at(b + 4, "s1_a1_latency", pk(0, 0, 0, 0, 0), MA1);
        expect_at(b + 5, "s1_a1_commit", pk(3, 0, 0, 0, 0), MA1 | MA2);
        expect_at(b + 12, "s1_a2_wait", pk(3, 0, 0, 0, 0), MA1 | MA2);
        expect_at(b + 13, "s1_a2_copy", pk(3, 3, 0, 0, 0), MALL);
        wait_cyc(b + 14);

        // S2: glitching B never commits
        b = cyc;
        for (int i = 0; i <= 22; i++) expect_at(b + i, "s2_glitch", pk(3, 3, 0, 0, 0), MALL);
        for (int i = 0; i < 10; i++) begin
            req_b = (i % 2 == 0) ? 3'd2 : 3'd5;
            wait_cyc(b + 2 * i + 2);
        end
        req_b = 3'd0;
        wait_cyc(b + 26);

        // S3: contested antenna, released by A
        b = cyc;
        req_a = 3'd4;
        expect_at(b + 4, "s3_a1_old", pk(3, 0, 0, 0, 0), MA1);
        expect_at(b + 5, "s3_a1_new", pk(4, 0, 0, 0, 0), MA1);
        wait_cyc(b + 6);
        b2 = cyc;
        req_b = 3'd4;
        for (int i = 0; i <= 8; i++) expect_at(b2 + i, "s3_b_blocked", 13'd0, MB1);
        expect_at(b2 + 4, "s3_conf_early", 13'd0, MCF);
        for (int i = 5; i <= 8; i++) expect_at(b2 + i, "s3_conf_set", 13'd1, MCF);
        wait_cyc(b2 + 8);
        b3 = cyc;
        req_a = 3'd0;
        expect_at(b3, "s3_a2_copy", pk(0, 4, 0, 0, 0), MA2);
        expect_at(b3 + 4, "s3_hold_a", pk(4, 0, 0, 0, 1), MA1 | MB1 | MCF);
        expect_at(b3 + 5, "s3_a_release", pk(0, 0, 0, 0, 1), MA1 | MB1 | MCF);
        expect_at(b3 + 6, "s3_b_commit", pk(0, 0, 4, 0, 0), MA1 | MB1 | MCF);
        wait_cyc(b3 + 6);
        req_b = 3'd0;
        expect_at(b3 + 21, "s3_settled", pk(0, 0, 0, 0, 0), MALL);
        wait_cyc(b3 + 22);

        // S4: simultaneous request for the same antenna
        b = cyc;
        req_a = 3'd6;
        req_b = 3'd6;
        expect_at(b + 4, "s4_pre", pk(0, 0, 0, 0, 0), MA1 | MB1 | MCF);
        for (int i = 5; i <= 10; i++)
            expect_at(b + i, "s4_a_wins", pk(6, 0, 0, 0, 1), MA1 | MB1 | MCF);
        wait_cyc(b + 10);
        b = cyc;
        req_a = 3'd0;
        req_b = 3'd0;
        expect_at(b + 2, "s4_conf_clear", 13'd0, MCF);
        expect_at(b + 15, "s4_settled", pk(0, 0, 0, 0, 0), MALL);
        wait_cyc(b + 16);

        // S5: second commit restarts the hold
        b = cyc;
        req_a = 3'd2;
        expect_at(b + 5, "s5_a_commit", pk(2, 0, 0, 0, 0), MA1 | MB1);
        wait_cyc(b + 5);
        req_b = 3'd1;
        expect_at(b + 9, "s5_b_pre", pk(2, 0, 0, 0, 0), MB1);
        expect_at(b + 10, "s5_b_commit", pk(2, 0, 1, 0, 0), MA1 | MB1);
        for (int i = 6; i <= 17; i++)
            expect_at(b + i, "s5_a2_held", pk(0, 0, 0, 0, 0), MA2 | MB2);
        expect_at(b + 18, "s5_copy_both", pk(2, 2, 1, 1, 0), MALL);
        wait_cyc(b + 19);

        // S6: asynchronous reset mid-hold, then invalid code
        b = cyc;
        req_a = 3'd5;
        expect_at(b + 5, "s6_a_commit", pk(5, 2, 1, 1, 0), MALL);
        wait_cyc(b + 8);
        #1 rst_n = 1'b0;
        expect_at(b + 8, "s6_async_reset", pk(0, 0, 0, 0, 0), MALL);
        expect_at(b + 9, "s6_in_reset", pk(0, 0, 0, 0, 0), MALL);
        req_a = 3'd7;
        req_b = 3'd0;
        wait_cyc(b + 10);
        b2 = cyc;
        rst_n = 1'b1;
        for (int i = 0; i <= 12; i++)
            expect_at(b2 + i, "s6_invalid_code", pk(0, 0, 0, 0, 0), MALL);
        wait_cyc(b2 + 13);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, required 0", sb.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
